// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for uart_program_loader and its byte receiver.
//   byte_t        : one serial byte
//   LOADER_SYNC   : frame sync byte
//   load_state_t  : loader FSM states (S_CSUM exists only when the
//                   LOADER_CHECKSUM_EN macro is defined)
//   rx_state_t    : byte receiver FSM states
// ---------------------------------------------------------------------------
package loader_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t LOADER_SYNC = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_HI    = 3'd2,
      S_LO    = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM  = 3'd4,
`endif
      S_RUN   = 3'd5
   } load_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
// 8N1 byte receiver: 2-flop synchronizer, falling-edge start detection with
// a half-bit re-check (glitch rejection), data sampled at bit centres LSB
// first. Strobes appear one cycle after the stop-bit sample.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   rx_i        : asynchronous serial input, idle high
//   byte_data   : last received byte (stable until the next byte shifts in)
//   byte_valid  : one-cycle strobe, stop bit was 1
//   frame_err   : one-cycle strobe, stop bit was 0 (byte must be discarded)
// ---------------------------------------------------------------------------
module uart_byte_rx
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  rx_i,
   output byte_t byte_data,
   output logic  byte_valid,
   output logic  frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             meta_q, sync_q, prev_q;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   byte_t            shift_q, shift_d;
   logic             valid_q, valid_d, ferr_q, ferr_d;
   logic             full_s, half_s;

   assign full_s = (cnt_q == FULL_LAST);
   assign half_s = (cnt_q == HALF_LAST);

   // Synchronizer chain plus one extra stage to see the falling edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Receiver state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Receiver next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE:  state_d = (prev_q && !sync_q) ? RX_START : RX_IDLE;
         // Line back high at the half-bit point means the edge was a glitch
         RX_START: state_d = half_s ? (sync_q ? RX_IDLE : RX_DATA) : RX_START;
         RX_DATA:  state_d = (full_s && (bit_q == 3'd7)) ? RX_STOP : RX_DATA;
         RX_STOP:  state_d = full_s ? RX_IDLE : RX_STOP;
         default:  state_d = RX_IDLE;
      endcase
   end

   // Bit timing, shifting and stop-bit evaluation
   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            bit_d = 3'd0;
         end
         RX_START: begin
            if (half_s) begin
               cnt_d = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (full_s) begin
               cnt_d   = {CNT_W{1'b0}};
               shift_d = {sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (full_s) begin
               cnt_d   = {CNT_W{1'b0}};
               valid_d = sync_q;
               ferr_d  = !sync_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: cnt_d = {CNT_W{1'b0}};
      endcase
   end

   // Receiver datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= {CNT_W{1'b0}};
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign byte_data  = shift_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
// Receives a framed Thumb program over UART (A5, N, N halfwords high byte
// first, optional XOR checksum) and writes it into CPU instruction memory,
// holding the CPU in reset until a complete valid frame has arrived.
// Optional feature: define LOADER_CHECKSUM_EN to require the checksum byte.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   uart_rx                  : serial input, 8N1, idle high
//   cpu_reset                : 1 unless a valid program is loaded (RUN)
//   write_instruction_index  : target index of the current write
//   write_instruction        : halfword of the current write
//   write_valid              : one-cycle write strobe
//   load_error               : sticky bad-frame flag, cleared by a sync byte
//   busy                     : 1 while a frame is being received
// ---------------------------------------------------------------------------
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int START_INDEX  = 10,
   parameter int TIMEOUT_CLKS = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_rx,
   output logic        cpu_reset,
   output logic [7:0]  write_instruction_index,
   output logic [15:0] write_instruction,
   output logic        write_valid,
   output logic        load_error,
   output logic        busy
);

   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
`ifdef LOADER_CHECKSUM_EN
   localparam load_state_t AFTER_LAST = S_CSUM;
`else
   localparam load_state_t AFTER_LAST = S_RUN;
`endif

   byte_t            rx_byte_s;
   logic             rx_valid_s, rx_ferr_s;
   load_state_t      state_q, state_d;
   byte_t            count_q, count_d, hw_q, hw_d, hi_q, hi_d, widx_q, widx_d;
   logic [15:0]      wdata_q, wdata_d;
   logic             wvalid_q, wvalid_d, err_q, err_d;
   logic             cpu_reset_q, cpu_reset_d, busy_q, busy_d;
   logic [TMO_W-1:0] tmo_q;
   logic             in_frame_s, tmo_s, abort_s, sync_s, last_s;
`ifdef LOADER_CHECKSUM_EN
   byte_t            csum_q, csum_d;
`endif

   uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rx_i      (uart_rx),
      .byte_data (rx_byte_s),
      .byte_valid(rx_valid_s),
      .frame_err (rx_ferr_s)
   );

   assign in_frame_s = (state_q != S_IDLE) && (state_q != S_RUN);
   assign tmo_s      = in_frame_s && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));
   // Framing errors and timeouts only matter inside a frame
   assign abort_s    = in_frame_s && (rx_ferr_s || tmo_s);
   assign sync_s     = rx_valid_s && (rx_byte_s == LOADER_SYNC);
   assign last_s     = ((hw_q + 8'd1) == count_q);

   // Loader state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Loader next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = sync_s ? S_COUNT : S_IDLE;
         S_COUNT: begin
            if (abort_s)         state_d = S_IDLE;
            else if (rx_valid_s) state_d = (rx_byte_s == 8'd0) ? S_IDLE : S_HI;
            else                 state_d = S_COUNT;
         end
         S_HI: begin
            if (abort_s)         state_d = S_IDLE;
            else if (rx_valid_s) state_d = S_LO;
            else                 state_d = S_HI;
         end
         S_LO: begin
            if (abort_s)         state_d = S_IDLE;
            else if (rx_valid_s) state_d = last_s ? AFTER_LAST : S_HI;
            else                 state_d = S_LO;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (abort_s)         state_d = S_IDLE;
            else if (rx_valid_s) state_d = (rx_byte_s == csum_q) ? S_RUN : S_IDLE;
            else                 state_d = S_CSUM;
         end
`endif
         S_RUN:   state_d = sync_s ? S_COUNT : S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Loader outputs and datapath next values
   always_comb begin
      count_d  = count_q;
      hw_d     = hw_q;
      hi_d     = hi_q;
      widx_d   = widx_q;
      wdata_d  = wdata_q;
      wvalid_d = 1'b0;
      err_d    = err_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (state_q)
         S_IDLE, S_RUN: begin
            if (sync_s) begin
               err_d = 1'b0;
               hw_d  = 8'd0;
`ifdef LOADER_CHECKSUM_EN
               csum_d = 8'h00;
`endif
            end else begin
               err_d = err_q;
            end
         end
         S_COUNT: begin
            if (abort_s) begin
               err_d = 1'b1;
            end else if (rx_valid_s) begin
               count_d = rx_byte_s;
               err_d   = (rx_byte_s == 8'd0);
            end else begin
               err_d = err_q;
            end
         end
         S_HI: begin
            if (abort_s) begin
               err_d = 1'b1;
            end else if (rx_valid_s) begin
               hi_d = rx_byte_s;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_byte_s;
`endif
            end else begin
               hi_d = hi_q;
            end
         end
         S_LO: begin
            if (abort_s) begin
               err_d = 1'b1;
            end else if (rx_valid_s) begin
               wvalid_d = 1'b1;
               // 8-bit add wraps the index silently past 255
               widx_d   = 8'(START_INDEX) + hw_q;
               wdata_d  = {hi_q, rx_byte_s};
               hw_d     = hw_q + 8'd1;
`ifdef LOADER_CHECKSUM_EN
               csum_d   = csum_q ^ rx_byte_s;
`endif
            end else begin
               wvalid_d = 1'b0;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (abort_s) begin
               err_d = 1'b1;
            end else if (rx_valid_s) begin
               err_d = (rx_byte_s != csum_q);
            end else begin
               err_d = err_q;
            end
         end
`endif
         default: err_d = err_q;
      endcase
      // Registered from the next state so cpu_reset/busy move one cycle after the strobe
      cpu_reset_d = (state_d != S_RUN);
      busy_d      = (state_d != S_IDLE) && (state_d != S_RUN);
   end

   // Loader datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q     <= 8'd0;
         hw_q        <= 8'd0;
         hi_q        <= 8'h00;
         widx_q      <= 8'(START_INDEX);
         wdata_q     <= 16'h0000;
         wvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q      <= 8'h00;
`endif
      end else begin
         count_q     <= count_d;
         hw_q        <= hw_d;
         hi_q        <= hi_d;
         widx_q      <= widx_d;
         wdata_q     <= wdata_d;
         wvalid_q    <= wvalid_d;
         err_q       <= err_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   // Inter-byte timeout: counts idle cycles inside a frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q <= {TMO_W{1'b0}};
      end else if (!in_frame_s || rx_valid_s || rx_ferr_s || tmo_s) begin
         tmo_q <= {TMO_W{1'b0}};
      end else begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   assign cpu_reset               = cpu_reset_q;
   assign write_instruction_index = widx_q;
   assign write_instruction       = wdata_q;
   assign write_valid             = wvalid_q;
   assign load_error              = err_q;
   assign busy                    = busy_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_program_loader
// Directed bench: a table of frames with expected writes and flags, plus
// hand-written sequences for index wrap, timeout, glitch, framing error and
// mid-frame reset. Two DUTs share the serial line (START_INDEX 10 and 255).
// ---------------------------------------------------------------------------
module tb_uart_program_loader;

   localparam int CPB = 8;
   localparam int TMO = 400;

   logic        clk = 1'b0;
   logic        reset, uart_rx;
   logic        rst0, wv0, err0, busy0, rst1, wv1, err1, busy1;
   logic [7:0]  idx0, idx1;
   logic [15:0] dat0, dat1;

   always #5 clk = ~clk;

   uart_program_loader #(.CLKS_PER_BIT(CPB), .START_INDEX(10), .TIMEOUT_CLKS(TMO)) dut0 (
      .clk(clk), .reset(reset), .uart_rx(uart_rx), .cpu_reset(rst0),
      .write_instruction_index(idx0), .write_instruction(dat0), .write_valid(wv0),
      .load_error(err0), .busy(busy0));

   uart_program_loader #(.CLKS_PER_BIT(CPB), .START_INDEX(255), .TIMEOUT_CLKS(TMO)) dut1 (
      .clk(clk), .reset(reset), .uart_rx(uart_rx), .cpu_reset(rst1),
      .write_instruction_index(idx1), .write_instruction(dat1), .write_valid(wv1),
      .load_error(err1), .busy(busy1));

   typedef struct packed {
      logic [3:0]  nb;     // frame bytes, excluding checksum
      logic [79:0] by;     // first byte in [79:72]
      logic        cs_en;  // append checksum byte in checksum builds
      logic [7:0]  cs;
      logic [1:0]  nw;     // expected writes
      logic [71:0] wr;     // {idx,data} per write, first in [71:48]
      logic        e_rst, e_err, e_busy;
      logic        cf, cr; // check cpu_reset fall / rise timing
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fall_cyc, rise_cyc;
   int strobes[$];
   logic [7:0]  wq_idx[$], w1_idx[$];
   logic [15:0] wq_dat[$], w1_dat[$];
   logic        wq_ok[$];
   logic        prev_bv = 1'b0;
   logic        prev_rst = 1'b1;
   vec_t        vecs[7];

   always @(posedge clk) cyc <= cyc + 1;

   // Write log and timing references, sampled away from the active edge
   always @(negedge clk) begin
      if (wv0) begin
         wq_idx.push_back(idx0);
         wq_dat.push_back(dat0);
         wq_ok.push_back(prev_bv);
      end
      if (wv1) begin
         w1_idx.push_back(idx1);
         w1_dat.push_back(dat1);
      end
      if (prev_rst && !rst0) fall_cyc = cyc;
      if (!prev_rst && rst0) rise_cyc = cyc;
      if (dut0.u_rx.byte_valid) strobes.push_back(cyc);
      prev_bv  = dut0.u_rx.byte_valid;
      prev_rst = rst0;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [3:0] nb, input logic [79:0] by, input logic cs_en,
                               input logic [7:0] cs, input logic [1:0] nw, input logic [71:0] wr,
                               input logic e_rst, input logic e_err, input logic e_busy,
                               input logic cf, input logic cr);
      mk = '{nb:nb, by:by, cs_en:cs_en, cs:cs, nw:nw, wr:wr,
             e_rst:e_rst, e_err:e_err, e_busy:e_busy, cf:cf, cr:cr};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      wq_idx.delete(); wq_dat.delete(); wq_ok.delete();
      w1_idx.delete(); w1_dat.delete(); strobes.delete();
      fall_cyc = -1;
      rise_cyc = -1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(CPB);
      end
      uart_rx = stop_bit;
      tick(CPB);
      uart_rx = 1'b1;
      if (!stop_bit) tick(2 * CPB);
   endtask

   task automatic apply(input vec_t v, input string tag);
      logic [23:0] w;
      clr();
      for (int k = 0; k < int'(v.nb); k++) send_byte(v.by[79-8*k -: 8], 1'b1);
`ifdef LOADER_CHECKSUM_EN
      if (v.cs_en) send_byte(v.cs, 1'b1);
`endif
      tick(3);
      @(negedge clk);
      chk({tag, " cpu_reset"}, 32'(rst0), 32'(v.e_rst));
      chk({tag, " load_error"}, 32'(err0), 32'(v.e_err));
      chk({tag, " busy"}, 32'(busy0), 32'(v.e_busy));
      chk({tag, " nwrites"}, 32'(wq_idx.size()), 32'(v.nw));
      for (int k = 0; k < int'(v.nw); k++) begin
         w = v.wr[71-24*k -: 24];
         chk($sformatf("%s w%0d idx", tag, k), 32'(wq_idx[k]), 32'(w[23:16]));
         chk($sformatf("%s w%0d data", tag, k), 32'(wq_dat[k]), 32'(w[15:0]));
         chk($sformatf("%s w%0d after strobe", tag, k), 32'(wq_ok[k]), 32'(1'b1));
      end
      if (v.cf) chk({tag, " fall timing"}, 32'(fall_cyc), 32'(strobes[$] + 1));
      if (v.cr) chk({tag, " rise timing"}, 32'(rise_cyc), 32'(strobes[0] + 1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " cpu_reset"}, 32'(rst0), 32'(1'b1));
      chk({tag, " write_valid"}, 32'(wv0), 32'(1'b0));
      chk({tag, " index"}, 32'(idx0), 32'(8'd10));
      chk({tag, " index1"}, 32'(idx1), 32'(8'd255));
      chk({tag, " data"}, 32'(dat0), 32'(16'h0000));
      chk({tag, " load_error"}, 32'(err0), 32'(1'b0));
      chk({tag, " busy"}, 32'(busy0), 32'(1'b0));
   endtask

   initial begin
      // Table: frames applied back to back; state carries between rows
      vecs[0] = mk(4'd6, 80'hA5_02_20_21_00_22_00_00_00_00, 1'b1, 8'h23, 2'd2,
                   72'h0A_2021_0B_0022_00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
      vecs[1] = mk(4'd6, 80'hA5_02_20_21_00_22_00_00_00_00, 1'b1, 8'h24, 2'd2,
                   72'h0A_2021_0B_0022_00_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`else
      vecs[1] = mk(4'd6, 80'hA5_02_20_21_00_22_00_00_00_00, 1'b1, 8'h24, 2'd2,
                   72'h0A_2021_0B_0022_00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
      vecs[2] = mk(4'd4, 80'hA5_01_AB_CD_00_00_00_00_00_00, 1'b1, 8'h66, 2'd1,
                   72'h0A_ABCD_00_0000_00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[3] = mk(4'd2, 80'hA5_00_00_00_00_00_00_00_00_00, 1'b0, 8'h00, 2'd0,
                   72'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      vecs[4] = mk(4'd1, 80'h12_00_00_00_00_00_00_00_00_00, 1'b0, 8'h00, 2'd0,
                   72'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[5] = mk(4'd8, 80'hA5_03_01_02_03_04_05_06_00_00, 1'b1, 8'h07, 2'd3,
                   72'h0A_0102_0B_0304_0C_0506, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[6] = mk(4'd3, 80'hA5_03_12_00_00_00_00_00_00_00, 1'b0, 8'h00, 2'd0,
                   72'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

      reset   = 1'b1;
      uart_rx = 1'b1;
      tick(3);
      @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;
      tick(2);
      @(negedge clk);
      chk_reset_vals("post-reset");

      // Index wrap on the START_INDEX=255 instance
      apply(mk(4'd6, 80'hA5_02_11_22_33_44_00_00_00_00, 1'b1, 8'h44, 2'd2,
               72'h0A_1122_0B_3344_00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "wrap0");
      chk("wrap1 nwrites", 32'(w1_idx.size()), 32'd2);
      chk("wrap1 w0 idx", 32'(w1_idx[0]), 32'h0000_00FF);
      chk("wrap1 w0 data", 32'(w1_dat[0]), 32'h0000_1122);
      chk("wrap1 w1 idx", 32'(w1_idx[1]), 32'h0000_0000);
      chk("wrap1 w1 data", 32'(w1_dat[1]), 32'h0000_3344);
      chk("wrap1 cpu_reset", 32'(rst1), 32'd0);

      for (int i = 0; i < 7; i++) apply(vecs[i], $sformatf("v%0d", i));

      // Timeout while waiting for the low byte (continues from row 6)
      tick(TMO / 2);
      @(negedge clk);
      chk("tmo early busy", 32'(busy0), 32'd1);
      chk("tmo early load_error", 32'(err0), 32'd0);
      tick(TMO / 2 + 10);
      @(negedge clk);
      chk("tmo load_error", 32'(err0), 32'd1);
      chk("tmo busy", 32'(busy0), 32'd0);
      chk("tmo cpu_reset", 32'(rst0), 32'd1);
      apply(mk(4'd4, 80'hA5_01_AB_CD_00_00_00_00_00_00, 1'b1, 8'h66, 2'd1,
               72'h0A_ABCD_00_0000_00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "after-tmo");

      // Short low glitch while in HI must not produce a byte
      apply(mk(4'd2, 80'hA5_02_00_00_00_00_00_00_00_00, 1'b0, 8'h00, 2'd0,
               72'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1), "pre-glitch");
      uart_rx = 1'b0;
      tick(2);
      uart_rx = 1'b1;
      tick(2 * CPB);
      apply(mk(4'd4, 80'h5A_5B_5C_5D_00_00_00_00_00_00, 1'b1, 8'h00, 2'd2,
               72'h0A_5A5B_0B_5C5D_00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "glitch");

      // Framing error while in HI
      apply(mk(4'd2, 80'hA5_02_00_00_00_00_00_00_00_00, 1'b0, 8'h00, 2'd0,
               72'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1), "pre-ferr");
      send_byte(8'h33, 1'b0);
      tick(3);
      @(negedge clk);
      chk("ferr load_error", 32'(err0), 32'd1);
      chk("ferr busy", 32'(busy0), 32'd0);
      chk("ferr cpu_reset", 32'(rst0), 32'd1);
      chk("ferr nwrites", 32'(wq_idx.size()), 32'd0);

      // Reset in the middle of a frame
      apply(mk(4'd3, 80'hA5_01_77_00_00_00_00_00_00_00, 1'b0, 8'h00, 2'd0,
               72'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "pre-reset");
      reset = 1'b1;
      #1;
      chk_reset_vals("mid-reset");
      tick(3);
      reset = 1'b0;
      tick(2);
      apply(mk(4'd4, 80'hA5_01_12_34_00_00_00_00_00_00, 1'b1, 8'h26, 2'd1,
               72'h0A_1234_00_0000_00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "after-reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Receives a Thumb program over the board's serial line and writes it into the CPU's instruction memory through the CPU write port (`write_instruction_index` / `write_instruction`). While a download is in progress it holds the CPU in reset, and it releases the CPU once a complete, valid frame has arrived. It sits directly upstream of `CPU` and replaces hard-coded program ROM sequencing, so programs can be changed without resynthesis.

## Interface
- `CLKS_PER_BIT`, 868: `clk` cycles per UART bit (100 MHz / 115200).
- `START_INDEX`, 10: instruction index that receives the first halfword.
- `TIMEOUT_CLKS`, 1_000_000: maximum idle `clk` cycles between bytes inside a frame.
- `clk`  in  1  system clock; the same clock that drives the CPU write port.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  serial input, 8N1, idle high; asynchronous to `clk`.
- `cpu_reset`  out  1  drives CPU `reset`; 1 while no valid program is loaded or a load is in progress.
- `write_instruction_index`  out  8  target index for the current write.
- `write_instruction`  out  16  halfword to write.
- `write_valid`  out  1  one-cycle strobe; index and data are valid in that cycle.
- `load_error`  out  1  sticky; set on a bad frame, cleared by the next sync byte.
- `busy`  out  1  1 in any state except IDLE and RUN.

## Operation
- Frame format: `0xA5` sync, count `N` (1..255), then N halfwords of 2 bytes each, then a checksum byte (only with `LOADER_CHECKSUM_EN`).
- The first byte of each halfword is placed in `[15:8]` and the second in `[7:0]`.
- States:
  - IDLE: power-up state; `cpu_reset=1`. Waits for the sync byte; all other bytes are ignored.
  - COUNT: receives N. N=0 → set `load_error`, go to IDLE.
  - HI: receives the high byte. After it, go to LO.
  - LO: receives the low byte and strobes the write. After it, go to HI, or to CSUM/RUN once halfword N is done.
  - CSUM: compares the received byte with the XOR of all payload bytes. Match → RUN. Mismatch → set `load_error`, go to IDLE.
  - RUN: `cpu_reset=0`.
- In RUN, a sync byte reasserts `cpu_reset` in the next cycle and moves to COUNT (reload). Any other byte in RUN is ignored.
- Index arithmetic: halfword k (0-based) is written to `(START_INDEX + k) mod 256`. The index wraps silently.
- Framing error (stop bit sampled 0): the byte is discarded. In a non-IDLE/RUN state, set `load_error` and go to IDLE. In IDLE or RUN, the byte is simply ignored.
- Timeout: `TIMEOUT_CLKS` cycles with no byte while in COUNT/HI/LO/CSUM → set `load_error`, go to IDLE.
- Reset mid-load: all state clears and the FSM returns to IDLE with `cpu_reset=1`. Writes already made are not undone.

## Timing
- Reset values: `cpu_reset=1`, `write_valid=0`, `write_instruction_index=START_INDEX`, `write_instruction=0`, `load_error=0`, `busy=0`.
- `uart_rx` passes through a 2-flop synchronizer.
- Start bit:
  - detected on a falling edge and re-checked at the half-bit point;
  - if high at that point, the start is treated as a glitch and the receiver returns to idle.
- Data bits are sampled at bit centres, LSB first.
- The byte strobe occurs 1 cycle after the stop-bit sample.
- `write_valid` is high the cycle after the low-byte strobe. Index and data hold their values until the next write.
- `cpu_reset` falls 1 cycle after the final byte's strobe (checksum byte, or the last low byte when checksum is off).

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - the CSUM state and checksum byte are required;
  - a mismatch sets `load_error` and keeps the CPU in reset.
- Undefined:
  - there is no checksum byte and the CSUM state is removed;
  - the transition after halfword N goes straight to RUN.

## Structure
- Shared package `loader_pkg`:
  - the FSM state enum;
  - the `LOADER_SYNC = 8'hA5` constant;
  - the byte type.
- Sub-module `uart_byte_rx` (parameter `CLKS_PER_BIT`): contains the synchronizer and bit sampling. Outputs are `byte_data[7:0]`, `byte_valid` and `frame_err`.
- The FSM, index counter, checksum accumulator and timeout counter live in `uart_program_loader`.

## Test plan
- Checksum on, send `A5 02 20 21 00 22 23` → writes idx10=`0x2021`, idx11=`0x0022`. `cpu_reset` falls 1 cycle after the `23` strobe; `load_error=0`.
- The same frame with checksum `24` → both writes occur, `cpu_reset` stays 1, `load_error=1`, FSM returns to IDLE.
- `START_INDEX=255`, `A5 02 11 22 33 44 <xor>` → idx255=`0x1122`, idx0=`0x3344` (wrap).
- Send `A5 03 12`, then stay idle for `TIMEOUT_CLKS+10` cycles → `load_error=1`, IDLE, `cpu_reset=1`. A subsequent valid frame clears `load_error` and loads normally.
- In RUN, send `A5` → `cpu_reset=1` the cycle after the strobe. Send `00` → `load_error=1`.
- A 0.3-bit low glitch on `uart_rx`, then a byte with stop bit 0 while in HI → glitch ignored, framing error sets `load_error`, FSM returns to IDLE. Assert `reset` mid-frame → all outputs return to their reset values.
